// File: rtl/eth_frame_tx_param.sv
// Ethernet II frame transmitter: byte payload stream in, MII-style nibble frame out
// with preamble, SFD, fixed header, zero padding, internally computed CRC-32 FCS and IPG.
module eth_frame_tx_param #(
  parameter logic [47:0] DEST_MAC         = 48'hAABBCCDDEEFF,
  parameter logic [47:0] SRC_MAC          = 48'h112233445566,
  parameter logic [15:0] ETHER_TYPE       = 16'h0800,
  parameter int          PREAMBLE_NIBBLES = 14,
  parameter int          IPG_NIBBLES      = 24,
  parameter int          MIN_PAYLOAD      = 46,
  parameter int          MAX_PAYLOAD      = 1500
) (
  input  logic        clock,
  input  logic        reset_pin,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [3:0]  data_out,
  output logic        final_data_valid,
  output logic        tx_busy,
  output logic        frame_done,
  output logic        tx_error,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_HEADER   = 3'd3,
    ST_PAYLOAD  = 3'd4,
    ST_PAD      = 3'd5,
    ST_FCS      = 3'd6,
    ST_IPG      = 3'd7
  } state_t;

  localparam logic [111:0] HEADER_BITS = {DEST_MAC, SRC_MAC, ETHER_TYPE};
  localparam logic [7:0]   PRE_LAST    = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0]   IPG_LAST    = 8'(IPG_NIBBLES - 1);
  localparam logic [10:0]  MIN_BYTES   = 11'(MIN_PAYLOAD);
  localparam logic [10:0]  MAX_BYTES   = 11'(MAX_PAYLOAD);
  localparam logic [31:0]  CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]  CRC_INIT    = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Header nibble idx: byte idx/2 counted from the MSB end, low nibble on even idx
  function automatic logic [3:0] header_nibble(input logic [4:0] idx);
    logic [6:0] base;
    logic [7:0] b;
    base = 7'd104 - {idx[4:1], 3'b000};
    b    = HEADER_BITS[base +: 8];
    return idx[0] ? b[7:4] : b[3:0];
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  nib_cnt_r, nib_cnt_s;
  logic [10:0] byte_cnt_r, byte_cnt_s;
  logic        phase_r, phase_s;
  logic        last_r, last_s;
  logic        flush_r, flush_s;
  logic [7:0]  byte_r;
  logic [31:0] crc_r, crc_next_s, fcs_s;
  logic        load_s, abort_s, done_s;
  logic [3:0]  data_s;
  logic        valid_s;

  // CRC folds in the nibble currently on data_out while it belongs to the covered region
  always_comb begin
    crc_next_s = crc_r;
    if ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD) || (state_r == ST_PAD)) begin
      crc_next_s = crc32_nibble(crc_r, data_out);
    end else begin
      crc_next_s = crc_r;
    end
    fcs_s = ~crc_next_s;
  end

  // Ready depends only on the phase of the nibble being emitted
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_HEADER:  in_ready = (nib_cnt_r == 8'd27);
      ST_PAYLOAD: in_ready = phase_r & ~last_r;
      ST_IPG:     in_ready = flush_r;
      default:    in_ready = 1'b0;
    endcase
  end

  // Next-state logic; state_r describes the nibble presently on data_out
  always_comb begin
    state_s    = state_r;
    nib_cnt_s  = nib_cnt_r;
    byte_cnt_s = byte_cnt_r;
    phase_s    = phase_r;
    last_s     = last_r;
    flush_s    = flush_r;
    load_s     = 1'b0;
    abort_s    = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s   = ST_PREAMBLE;
          nib_cnt_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (nib_cnt_r == PRE_LAST) begin
          state_s   = ST_SFD;
          nib_cnt_s = 8'd0;
        end else begin
          nib_cnt_s = nib_cnt_r + 8'd1;
        end
      end
      ST_SFD: begin
        if (nib_cnt_r == 8'd1) begin
          state_s   = ST_HEADER;
          nib_cnt_s = 8'd0;
        end else begin
          nib_cnt_s = nib_cnt_r + 8'd1;
        end
      end
      ST_HEADER: begin
        if (nib_cnt_r != 8'd27) begin
          nib_cnt_s = nib_cnt_r + 8'd1;
        end else if (in_valid) begin
          state_s    = ST_PAYLOAD;
          phase_s    = 1'b0;
          byte_cnt_s = 11'd1;
          last_s     = in_last;
          load_s     = 1'b1;
        end else begin
          state_s   = ST_IPG;
          nib_cnt_s = 8'd0;
          abort_s   = 1'b1;
          flush_s   = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (!phase_r) begin
          phase_s = 1'b1;
        end else if (last_r) begin
          phase_s   = 1'b0;
          nib_cnt_s = 8'd0;
          if (byte_cnt_r < MIN_BYTES) begin
            state_s = ST_PAD;
          end else begin
            state_s = ST_FCS;
          end
        end else if (!in_valid) begin
          state_s   = ST_IPG;
          nib_cnt_s = 8'd0;
          abort_s   = 1'b1;
          flush_s   = 1'b0;
        end else if (byte_cnt_r == MAX_BYTES) begin
          // Oversize: drop the frame and swallow the rest of the source packet in IPG
          state_s   = ST_IPG;
          nib_cnt_s = 8'd0;
          abort_s   = 1'b1;
          flush_s   = ~in_last;
        end else begin
          phase_s    = 1'b0;
          byte_cnt_s = byte_cnt_r + 11'd1;
          last_s     = in_last;
          load_s     = 1'b1;
        end
      end
      ST_PAD: begin
        if (!phase_r) begin
          phase_s = 1'b1;
        end else begin
          phase_s    = 1'b0;
          byte_cnt_s = byte_cnt_r + 11'd1;
          if ((byte_cnt_r + 11'd1) == MIN_BYTES) begin
            state_s   = ST_FCS;
            nib_cnt_s = 8'd0;
          end else begin
            state_s = ST_PAD;
          end
        end
      end
      ST_FCS: begin
        if (nib_cnt_r == 8'd7) begin
          state_s   = ST_IPG;
          nib_cnt_s = 8'd0;
          done_s    = 1'b1;
        end else begin
          nib_cnt_s = nib_cnt_r + 8'd1;
        end
      end
      ST_IPG: begin
        if (flush_r && in_valid && in_last) begin
          flush_s = 1'b0;
        end else begin
          flush_s = flush_r;
        end
        if (nib_cnt_r != IPG_LAST) begin
          nib_cnt_s = nib_cnt_r + 8'd1;
        end else if (flush_s) begin
          state_s = ST_IPG;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Nibble to register for the phase being entered
  always_comb begin
    data_s  = 4'h0;
    valid_s = 1'b0;
    case (state_s)
      ST_IDLE:     begin data_s = 4'h0; valid_s = 1'b0; end
      ST_PREAMBLE: begin data_s = 4'h5; valid_s = 1'b1; end
      ST_SFD:      begin data_s = (nib_cnt_s == 8'd0) ? 4'h5 : 4'hD; valid_s = 1'b1; end
      ST_HEADER:   begin data_s = header_nibble(nib_cnt_s[4:0]); valid_s = 1'b1; end
      ST_PAYLOAD:  begin data_s = phase_s ? byte_r[7:4] : in_data[3:0]; valid_s = 1'b1; end
      ST_PAD:      begin data_s = 4'h0; valid_s = 1'b1; end
      ST_FCS:      begin data_s = fcs_s[{nib_cnt_s[2:0], 2'b00} +: 4]; valid_s = 1'b1; end
      ST_IPG:      begin data_s = 4'h0; valid_s = 1'b0; end
      default:     begin data_s = 4'h0; valid_s = 1'b0; end
    endcase
  end

  // State, counters, CRC and registered outputs
  always_ff @(posedge clock or negedge reset_pin) begin
    if (!reset_pin) begin
      state_r          <= ST_IDLE;
      nib_cnt_r        <= 8'd0;
      byte_cnt_r       <= 11'd0;
      phase_r          <= 1'b0;
      last_r           <= 1'b0;
      flush_r          <= 1'b0;
      byte_r           <= 8'd0;
      crc_r            <= CRC_INIT;
      data_out         <= 4'h0;
      final_data_valid <= 1'b0;
      tx_busy          <= 1'b0;
      frame_done       <= 1'b0;
      tx_error         <= 1'b0;
      frames_sent      <= 16'd0;
    end else begin
      state_r          <= state_s;
      nib_cnt_r        <= nib_cnt_s;
      byte_cnt_r       <= byte_cnt_s;
      phase_r          <= phase_s;
      last_r           <= last_s;
      flush_r          <= flush_s;
      if (load_s) begin
        byte_r <= in_data;
      end
      crc_r            <= (state_r == ST_IDLE) ? CRC_INIT : crc_next_s;
      data_out         <= data_s;
      final_data_valid <= valid_s;
      tx_busy          <= (state_s != ST_IDLE);
      frame_done       <= done_s;
      tx_error         <= abort_s;
      if (done_s) begin
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

endmodule
